// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: alternating priority between a CPU (m0) and a
// DMA (m1) in front of one intercon master port, with a timeout that
// self-terminates a hung transfer by returning ERR_DATA and pulsing bus_err.
module wb_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_STB,
    input  logic        m0_WE,
    input  logic [31:0] m0_ADDR,
    input  logic [31:0] m0_DAT_I,
    output logic [31:0] m0_DAT_O,
    output logic        m0_ACK,
    input  logic        m1_STB,
    input  logic        m1_WE,
    input  logic [31:0] m1_ADDR,
    input  logic [31:0] m1_DAT_I,
    output logic [31:0] m1_DAT_O,
    output logic        m1_ACK,
    output logic        s_STB,
    output logic        s_WE,
    output logic [31:0] s_ADDR,
    output logic [31:0] s_DAT_O,
    input  logic [31:0] s_DAT_I,
    input  logic        s_ACK,
    output logic [1:0]  grant,
    output logic        bus_err
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    state_t      state, next_state;
    logic        last_grant;   // 0 = m0 owned the bus last, 1 = m1
    logic [15:0] cnt;

    logic        granted;
    logic        sel_stb;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_dat;
    logic        tmo;
    logic        done;

    // Request signals of whichever master currently owns the bus.
    always_comb begin
        sel_stb  = 1'b0;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_dat  = '0;
        case (state)
            GNT0: begin
                sel_stb  = m0_STB;
                sel_we   = m0_WE;
                sel_addr = m0_ADDR;
                sel_dat  = m0_DAT_I;
            end
            GNT1: begin
                sel_stb  = m1_STB;
                sel_we   = m1_WE;
                sel_addr = m1_ADDR;
                sel_dat  = m1_DAT_I;
            end
            default: ;
        endcase
    end

    // A real slave ACK on the limit cycle beats the timeout.
    assign granted = (state != IDLE);
    assign tmo     = granted && sel_stb && !s_ACK && (cnt == LIMIT);
    assign done    = s_ACK || tmo;

    // Next-state: alternate on contention, release after ACK, abort or timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m0_STB && m1_STB) next_state = last_grant ? GNT0 : GNT1;
                else if (m0_STB)      next_state = GNT0;
                else if (m1_STB)      next_state = GNT1;
            end
            GNT0, GNT1: begin
                if (!sel_stb || done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State, priority memory and timeout counter; counter sits at 0 in IDLE
    // so every grant starts counting from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE)
                last_grant <= (next_state == GNT1);
            if (state == IDLE)
                cnt <= '0;
            else if (!s_ACK)
                cnt <= cnt + 16'd1;
        end
    end

    // Output routing; everything is derived from state so reset clears it at once.
    always_comb begin
        grant    = state;
        bus_err  = tmo;
        s_STB    = granted && sel_stb && !tmo;
        s_WE     = granted && sel_we;
        s_ADDR   = sel_addr;
        s_DAT_O  = sel_dat;
        m0_ACK   = 1'b0;
        m1_ACK   = 1'b0;
        m0_DAT_O = '0;
        m1_DAT_O = '0;
        if (state == GNT0) begin
            m0_ACK   = done;
            m0_DAT_O = tmo ? ERR_DATA : s_DAT_I;
        end
        if (state == GNT1) begin
            m1_ACK   = done;
            m1_DAT_O = tmo ? ERR_DATA : s_DAT_I;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with TIMEOUT = 4: single read, contention and
// alternation, write routing, abort, timeout, ACK-on-limit and mid-transfer reset.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_STB, m0_WE, m1_STB, m1_WE, s_ACK;
    logic [31:0] m0_ADDR, m0_DAT_I, m1_ADDR, m1_DAT_I, s_DAT_I;
    logic [31:0] m0_DAT_O, m1_DAT_O, s_ADDR, s_DAT_O;
    logic        m0_ACK, m1_ACK, s_STB, s_WE, bus_err;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_STB(m0_STB), .m0_WE(m0_WE), .m0_ADDR(m0_ADDR), .m0_DAT_I(m0_DAT_I),
        .m0_DAT_O(m0_DAT_O), .m0_ACK(m0_ACK),
        .m1_STB(m1_STB), .m1_WE(m1_WE), .m1_ADDR(m1_ADDR), .m1_DAT_I(m1_DAT_I),
        .m1_DAT_O(m1_DAT_O), .m1_ACK(m1_ACK),
        .s_STB(s_STB), .s_WE(s_WE), .s_ADDR(s_ADDR), .s_DAT_O(s_DAT_O),
        .s_DAT_I(s_DAT_I), .s_ACK(s_ACK),
        .grant(grant), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        m0_STB = 0; m0_WE = 0; m0_ADDR = 0; m0_DAT_I = 0;
        m1_STB = 0; m1_WE = 0; m1_ADDR = 0; m1_DAT_I = 0;
        s_ACK = 0; s_DAT_I = 0;

        // Reset state, with requests and ACK active to prove they are masked
        #2;
        m0_STB = 1; s_ACK = 1; s_DAT_I = 32'h5555_AAAA;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_s_stb", s_STB, 0);
        chk("rst_m0_ack", m0_ACK, 0);
        chk("rst_m0_dat", m0_DAT_O, 0);
        chk("rst_s_addr", s_ADDR, 0);
        m0_STB = 0; s_ACK = 0; s_DAT_I = 0;
        #1 reset = 1'b1;

        // Single m0 read of 0x10, slave ACKs 2 cycles after s_STB
        tick();
        m0_STB = 1; m0_ADDR = 32'h0000_0010;
        #1;
        chk("rd_idle_grant", grant, 0);
        chk("rd_idle_s_stb", s_STB, 0);
        tick();
        chk("rd_g1_grant", grant, 2'b01);
        chk("rd_g1_s_stb", s_STB, 1);
        chk("rd_g1_s_addr", s_ADDR, 32'h10);
        chk("rd_g1_m0_ack", m0_ACK, 0);
        tick();
        chk("rd_g2_m0_ack", m0_ACK, 0);
        tick();
        s_ACK = 1; s_DAT_I = 32'h1234_5678;
        #1;
        chk("rd_ack_m0_ack", m0_ACK, 1);
        chk("rd_ack_m0_dat", m0_DAT_O, 32'h1234_5678);
        chk("rd_ack_m1_ack", m1_ACK, 0);
        chk("rd_ack_m1_dat", m1_DAT_O, 0);
        chk("rd_ack_bus_err", bus_err, 0);
        m0_STB = 0;
        tick();
        s_ACK = 0;
        #1;
        chk("rd_done_grant", grant, 0);
        chk("rd_done_m0_ack", m0_ACK, 0);

        // Contention after m0 last owned the bus: m1 write wins
        m0_STB = 1; m0_ADDR = 32'h40; m0_WE = 0;
        m1_STB = 1; m1_WE = 1; m1_ADDR = 32'h200; m1_DAT_I = 32'hA5A5_A5A5;
        tick();
        s_ACK = 1; s_DAT_I = 32'h1111_2222;
        #1;
        chk("wr_grant", grant, 2'b10);
        chk("wr_s_we", s_WE, 1);
        chk("wr_s_addr", s_ADDR, 32'h200);
        chk("wr_s_dat", s_DAT_O, 32'hA5A5_A5A5);
        chk("wr_m1_ack", m1_ACK, 1);
        chk("wr_m1_dat", m1_DAT_O, 32'h1111_2222);
        chk("wr_m0_ack", m0_ACK, 0);
        chk("wr_m0_dat", m0_DAT_O, 0);
        tick();
        chk("b2b_dead_grant", grant, 0);
        chk("b2b_dead_s_stb", s_STB, 0);
        tick();
        chk("alt_m0_grant", grant, 2'b01);
        chk("alt_m0_s_addr", s_ADDR, 32'h40);
        chk("alt_m0_s_we", s_WE, 0);
        chk("alt_m0_ack", m0_ACK, 1);
        tick();
        chk("alt_dead_grant", grant, 0);
        s_ACK = 0;
        tick();
        chk("alt_m1_grant", grant, 2'b10);

        // Abort: m1 drops STB without ACK; no ACK and back to IDLE
        m1_STB = 0; m0_STB = 0;
        #1;
        chk("abort_s_stb", s_STB, 0);
        chk("abort_m1_ack", m1_ACK, 0);
        tick();
        chk("abort_grant", grant, 0);
        chk("abort_m1_ack_after", m1_ACK, 0);

        // Timeout: slave never ACKs, TIMEOUT = 4
        m0_STB = 1; m0_ADDR = 32'h80; m1_WE = 0;
        tick();
        chk("tmo_g1_err", bus_err, 0);
        tick();
        tick();
        chk("tmo_g3_err", bus_err, 0);
        chk("tmo_g3_s_stb", s_STB, 1);
        tick();
        chk("tmo_g4_grant", grant, 2'b01);
        chk("tmo_g4_m0_ack", m0_ACK, 1);
        chk("tmo_g4_m0_dat", m0_DAT_O, 32'hDEAD_BEEF);
        chk("tmo_g4_err", bus_err, 1);
        chk("tmo_g4_s_stb", s_STB, 0);
        tick();
        chk("tmo_next_grant", grant, 0);
        chk("tmo_next_err", bus_err, 0);
        chk("tmo_next_m0_ack", m0_ACK, 0);

        // ACK on the limit cycle: slave data wins, no bus_err
        tick();
        chk("lim_g1_grant", grant, 2'b01);
        tick();
        tick();
        tick();
        s_ACK = 1; s_DAT_I = 32'hCAFE_0001;
        #1;
        chk("lim_m0_ack", m0_ACK, 1);
        chk("lim_m0_dat", m0_DAT_O, 32'hCAFE_0001);
        chk("lim_err", bus_err, 0);
        chk("lim_s_stb", s_STB, 1);
        m0_STB = 0;
        tick();
        s_ACK = 0;
        #1;
        chk("lim_done_grant", grant, 0);

        // Reset mid-transfer while m1 owns the bus
        m1_STB = 1; m1_ADDR = 32'h300;
        tick();
        s_ACK = 1; s_DAT_I = 32'h7777_0000;
        #1;
        chk("mrst_pre_grant", grant, 2'b10);
        chk("mrst_pre_m1_ack", m1_ACK, 1);
        reset = 1'b0;
        #1;
        chk("mrst_s_stb", s_STB, 0);
        chk("mrst_m1_ack", m1_ACK, 0);
        chk("mrst_grant", grant, 0);
        chk("mrst_m1_dat", m1_DAT_O, 0);
        s_ACK = 0; m0_STB = 1; m0_ADDR = 32'h10;
        #1 reset = 1'b1;
        #1;
        chk("mrst_rel_m1_ack", m1_ACK, 0);
        tick();
        chk("mrst_first_grant", grant, 2'b01);
        s_ACK = 1;
        tick();
        s_ACK = 0;
        #1;
        chk("mrst_dead_grant", grant, 0);
        tick();
        chk("mrst_second_grant", grant, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: number of granted cycles without s_ACK before the arbiter self-terminates; legal range 2..65535.
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m0_STB, m0_WE  input  1 each  master 0 (CPU) strobe and write enable.
REQ-006 m0_ADDR, m0_DAT_I  input  32 each  master 0 address and write data.
REQ-007 m0_DAT_O  output  32  read data to master 0.
REQ-008 m0_ACK  output  1  transfer-complete strobe to master 0.
REQ-009 m1_STB, m1_WE, m1_ADDR, m1_DAT_I, m1_DAT_O, m1_ACK: same widths and meanings as the m0 ports, for master 1 (DMA).
REQ-010 s_STB, s_WE  output  1 each  strobe and write enable to WB_intercon master port.
REQ-011 s_ADDR, s_DAT_O  output  32 each  address and write data to WB_intercon.
REQ-012 s_DAT_I  input  32  read data from WB_intercon.
REQ-013 s_ACK  input  1  acknowledge from WB_intercon.
REQ-014 grant  output  2  one-hot current owner (01 = m0, 10 = m1, 00 = idle).
REQ-015 bus_err  output  1  one-cycle pulse on timeout termination.

Function
REQ-016 FSM states SHALL be IDLE, GNT0 and GNT1, with grant equal to 00, 01 and 10 respectively.
REQ-017 IDLE: only m0_STB -> GNT0; only m1_STB -> GNT1; both -> grant the master not recorded in last_grant; neither -> stay.
REQ-018 last_grant (1 bit) SHALL update to the granted master on every IDLE->GNTn transition.
REQ-019 In GNTn, s_STB/s_WE/s_ADDR/s_DAT_O SHALL combinationally equal mn_STB/mn_WE/mn_ADDR/mn_DAT_I.
REQ-020 In IDLE, s_STB and s_WE SHALL be 0; s_ADDR and s_DAT_O are don't-care but SHALL be driven to 0.
REQ-021 In GNTn, mn_ACK SHALL equal s_ACK combinationally (zero added latency) and mn_DAT_O SHALL equal s_DAT_I.
REQ-022 The non-granted master's ACK SHALL be 0 and its DAT_O SHALL be 0 at all times.
REQ-023 GNTn -> IDLE on the clock edge where mn_ACK = 1; minimum request-to-ACK latency is therefore 1 idle arbitration cycle plus slave latency.
REQ-024 Back-to-back requests from one master SHALL each pass through IDLE (one dead cycle), so the other master wins arbitration if it is also requesting.
REQ-025 Abort: if mn_STB deasserts in GNTn without s_ACK, the FSM SHALL return to IDLE on the next edge with no ACK issued.
REQ-026 Timeout counter (16 bit) SHALL clear on entry to GNTn and increment each GNTn cycle without s_ACK.
REQ-027 When the count equals TIMEOUT-1 with s_ACK = 0: s_STB = 0, mn_ACK = 1, mn_DAT_O = ERR_DATA and bus_err = 1, all in that same cycle; the FSM then goes to IDLE.
REQ-028 If s_ACK and timeout coincide, s_ACK SHALL win: slave data is returned and bus_err stays 0.
REQ-029 bus_err SHALL never be high for more than one consecutive cycle per transaction.

Reset
REQ-030 reset = 0 SHALL immediately force IDLE, last_grant = 1 (m0 wins the first contention), counter = 0, grant = 00, bus_err = 0, all ACK/STB/WE = 0 and all data outputs = 0, regardless of clk.
REQ-031 Reset asserted mid-transaction SHALL drop s_STB and mn_ACK asynchronously; no ACK is issued for the aborted transfer after release.
REQ-032 After reset deasserts, arbitration SHALL resume from IDLE on the first rising edge.

Verification
REQ-033 m0 reads 0x0000_0010, slave ACKs 2 cycles after s_STB with 0x1234_5678 -> m0_ACK for 1 cycle, m0_DAT_O = 0x1234_5678, grant 01 then 00, m1_ACK stays 0.
REQ-034 m0 and m1 request on the same cycle right after reset, each holding STB -> grant order 01, 00, 10, 00, 01, ...; each master ACKed once per grant.
REQ-035 m1 writes 0xA5A5_A5A5 to 0x0000_0200 -> s_WE = 1, s_ADDR = 0x200, s_DAT_O = 0xA5A5_A5A5 while grant = 10.
REQ-036 m0 requests and the slave never ACKs, with TIMEOUT = 4 -> on the 4th granted cycle m0_ACK = 1, m0_DAT_O = 0xDEAD_BEEF, bus_err = 1, s_STB = 0; the next cycle is IDLE.
REQ-037 s_ACK arrives exactly on the TIMEOUT-1 count -> slave data is returned and bus_err = 0.
REQ-038 reset pulled low while grant = 10 and s_STB = 1 -> s_STB, m1_ACK and grant go to 0 immediately; after release, the first contention grants m0.
